// File: rtl/line_adaptor_pkg.sv
// Shared types and default widths for the cache-line to memory-burst adaptor.
package line_adaptor_pkg;

  localparam int DEF_LINE_W      = 256;
  localparam int DEF_BURST_W     = 64;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/line_adaptor_watchdog.sv
// Response watchdog: flags the cycle in which TIMEOUT_CYC consecutive beat-less
// transfer cycles have elapsed. Compiled only when LINE_ADAPTOR_TIMEOUT_EN is defined.
`ifdef LINE_ADAPTOR_TIMEOUT_EN
module line_adaptor_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active_i,
  input  logic beat_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] idle_q, idle_d;

  // Outside RD/WR the count is held at zero, which also clears it on accept.
  always_comb begin
    idle_d = '0;
    if (active_i && !beat_i) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end

  assign expired_o = active_i && !beat_i && (idle_q == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/burst_line_adaptor.sv
// Splits one LLC line read/write into BEATS memory beats with a one-cycle completion
// pulse. Optional response watchdog enabled by defining LINE_ADAPTOR_TIMEOUT_EN.
module burst_line_adaptor
  import line_adaptor_pkg::*;
#(
  parameter int LINE_W      = DEF_LINE_W,
  parameter int BURST_W     = DEF_BURST_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = (BURST_W > 0) ? LINE_W / BURST_W : 0;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (BURST_W <= 0 || (LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_geometry
    $error("burst_line_adaptor: LINE_W/BURST_W must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("burst_line_adaptor: TIMEOUT_CYC must be >= 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  wbuf_q, wbuf_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;
  logic               busy_q, busy_d;
  logic               timeout;

`ifdef LINE_ADAPTOR_TIMEOUT_EN
  logic err_q, err_d;

  line_adaptor_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .active_i  ((state_q == RD) || (state_q == WR)),
    .beat_i    (resp_i),
    .expired_o (timeout)
  );

  always_comb begin
    err_d = 1'b0;
    if (((state_q == RD) || (state_q == WR)) && timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    burst_d = burst_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Read wins a tie; a held write is picked up on the next IDLE cycle.
        if (read_i) begin
          state_d = RD;
          read_d  = 1'b1;
          cnt_d   = '0;
          addr_d  = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (write_i) begin
          state_d = WR;
          write_d = 1'b1;
          cnt_d   = '0;
          addr_d  = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wbuf_d  = line_i;
          burst_d = line_i[BURST_W-1:0];
        end
      end
      RD: begin
        if (timeout) begin
          read_d  = 1'b0;
          resp_d  = 1'b1;
          state_d = DONE;
        end else if (resp_i) begin
          line_d[cnt_q*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_nxt;
          if (cnt_q == LAST) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (timeout) begin
          write_d = 1'b0;
          resp_d  = 1'b1;
          state_d = DONE;
        end else if (resp_i) begin
          cnt_d = cnt_nxt;
          if (cnt_q == LAST) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            burst_d = wbuf_q[cnt_nxt*BURST_W +: BURST_W];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/burst_line_adaptor.md
# burst_line_adaptor

Parametrised bridge between the last-level cache and the burst memory interface. It converts one LINE_W-bit cache-line read or write into LINE_W/BURST_W consecutive memory beats. It buffers the line in both directions and returns a single-cycle completion pulse. It replaces the fixed 256/64 adaptor and adds line-aligned addressing, write-data capture, a busy flag and an optional response-timeout abort.

## Interface
- LINE_W, 256, cache line width in bits
- BURST_W, 64, memory beat width in bits; LINE_W % BURST_W == 0 and BEATS = LINE_W/BURST_W a power of two ≥ 2 (elaboration-time $error otherwise)
- ADDR_W, 32, address width
- TIMEOUT_CYC, 1024, idle-beat limit; used only with LINE_ADAPTOR_TIMEOUT_EN
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- line_i  in  LINE_W  write line from LLC
- line_o  out  LINE_W  assembled read line
- address_i  in  ADDR_W  LLC request address
- read_i / write_i  in  1  LLC read / write request, level, held until resp_o
- resp_o  out  1  one-cycle completion pulse
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  high with resp_o when the transfer was aborted
- burst_i  in  BURST_W  read beat from memory
- burst_o  out  BURST_W  write beat to memory
- address_o  out  ADDR_W  line-aligned memory address
- read_o / write_o  out  1  memory read / write request
- resp_i  in  1  memory beat acknowledge

## Operation
- States: IDLE, RD, WR, DONE. Beat counter is $clog2(BEATS) bits wide.
- IDLE:
  - read_i high → RD. Read has priority when read_i and write_i are both high; a write still held is accepted on the next IDLE.
  - write_i high only → WR.
  - On accept: address_o ← address_i with its low $clog2(LINE_W/8) bits zeroed; counter ← 0. On a write, line_i is captured into the write buffer.
- RD: read_o high.
  - Each cycle with resp_i high: line_o[cnt*BURST_W +: BURST_W] ← burst_i, and cnt increments.
  - On the beat where cnt == BEATS-1: read_o ← 0, → DONE.
- WR: write_o high, burst_o = buffer[cnt*BURST_W +: BURST_W] (registered).
  - Each cycle with resp_i high: cnt increments and burst_o advances to the next beat.
  - On the last beat: write_o ← 0, → DONE.
- DONE: resp_o high for exactly one cycle, then → IDLE. read_i and write_i are ignored in DONE.
- resp_i is ignored in IDLE and DONE.
- line_o holds the last completed line until the next read overwrites it beat by beat. The write buffer is independent of line_o.
- Asserting reset_n low mid-transfer aborts the transfer immediately: all registers clear and the adaptor is in IDLE. No resp_o is issued.

## Timing
- Reset values: line_o, burst_o, address_o = 0; read_o, write_o, resp_o, busy_o, err_o = 0; state = IDLE.
- Request sampled high at edge t → read_o/write_o and address_o valid from t+1.
- Last beat acknowledged at edge u → resp_o high in cycle u+1, and read_o/write_o are already low in that cycle.
- Read latency, request to resp_o: 1 + BEATS + (memory wait cycles) + 1 cycles.
- Requester rule: the LLC deasserts read_i/write_i in the cycle after resp_o. A request still high in the following IDLE cycle is treated as a new transfer.
- Back-to-back: a new request may be accepted in the cycle immediately after DONE.

## Configuration
- LINE_ADAPTOR_TIMEOUT_EN defined:
  - A watchdog counts consecutive RD/WR cycles without resp_i; it resets on each beat and on accept.
  - Reaching TIMEOUT_CYC drops read_o/write_o and moves to DONE.
  - In DONE, resp_o and err_o are both high for one cycle. line_o contents are then undefined for the aborted read.
- Not defined: no watchdog logic is generated, the adaptor waits indefinitely for resp_i, and err_o is tied 0.

## Structure
- Package line_adaptor_pkg: state enum (IDLE, RD, WR, DONE) and the default width localparams.
- Sub-module line_adaptor_watchdog holds the timeout counter and comparator. It is instantiated only under LINE_ADAPTOR_TIMEOUT_EN.
- FSM, beat counter and line/write buffers stay in burst_line_adaptor.

## Test plan
- Read, defaults, address_i=0x1234_5678, beats 0xA..A/0xB..B/0xC..C/0xD..D with resp_i back-to-back → address_o=0x1234_5660, line_o={D,C,B,A}, resp_o pulses once 6 cycles after accept.
- Write with line_i changed to all-zero the cycle after accept, resp_i gaps of 3 cycles → burst_o emits the original four beats in order, write_o holds through the gaps, resp_o pulses once.
- read_i and write_i raised together → read done first; write accepted in the next IDLE and done second; exactly two resp_o pulses.
- LINE_W=512, BURST_W=128 → 4 beats of 128 bits assembled correctly; address aligned to 64 bytes.
- reset_n pulsed low after beat 2 of a read → all outputs 0 asynchronously; a later read completes normally with a fresh line.
- With LINE_ADAPTOR_TIMEOUT_EN and TIMEOUT_CYC=16, resp_i held low after beat 1 → read_o drops after 16 idle cycles; resp_o and err_o are both high for one cycle.
